// File: rtl/rv32i_types.sv
// Shared RV32I fetch-side types: imem base address and the response
// record carried through the responder's delay pipeline.
package rv32i_types;

  localparam logic [31:0] IMEM_BASE = 32'h6000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } imem_rsp_t;

  // Widen a 4-bit byte read mask into a 32-bit bit mask.
  function automatic logic [31:0] expand_rmask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/imem_delay_line.sv
// Fixed-length shift register of imem responses. STAGES = 0 is a pure
// pass-through so the responder can use one structure for every latency.
module imem_delay_line
  import rv32i_types::*;
#(
  parameter int STAGES = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  imem_rsp_t rsp_i,
  output imem_rsp_t rsp_o
);

  generate
    if (STAGES == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = ^{clk, rst};
      assign rsp_o     = rsp_i;
    end else begin : g_shift
      imem_rsp_t stage_q [STAGES];

      // Advance every in-flight response one stage; reset drops them all.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q[0] <= rsp_i;
          for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign rsp_o = stage_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch-stage imem interface.
// Word-addressed backing array with a programming port, fixed in-order
// response latency, and a stall input for refusing individual requests.
module imem_responder
  import rv32i_types::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = IMEM_BASE,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  output logic        imem_err,
  input  logic        stall_inj,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

  // Contents are deliberately not reset; the array is loaded through prog_*.
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] reqOff;
  logic [31:0] reqIdx;
  logic        reqInRange;
  logic        reqErr;
  logic        accept;

  logic [31:0] progOff;
  logic [31:0] progIdx;
  logic        progOk;

  imem_rsp_t   readStage_d;
  imem_rsp_t   readStage_q;
  imem_rsp_t   outRsp;

  // An address below the base borrows on subtraction and is out of range
  // even though the wrapped index could look small.
  assign reqOff     = imem_addr - BASE_ADDR;
  assign reqIdx     = reqOff >> 2;
  assign reqInRange = (imem_addr >= BASE_ADDR) && (reqIdx < DEPTH_W32);
  assign reqErr     = (imem_addr[1:0] != 2'b00) || !reqInRange;
  assign accept     = !rst && (imem_rmask != 4'b0000) && !stall_inj;

  assign progOff = prog_addr - BASE_ADDR;
  assign progIdx = progOff >> 2;
  assign progOk  = (prog_addr[1:0] == 2'b00) && (prog_addr >= BASE_ADDR) &&
                   (progIdx < DEPTH_W32);

  // Build the response for an accepted request; idle cycles carry all zeros
  // so the outputs never expose stale data.
  always_comb begin
    readStage_d = '0;
    if (accept) begin
      readStage_d.valid = 1'b1;
      if (reqErr) begin
        readStage_d.err = 1'b1;
      end else begin
        readStage_d.rdata = mem[reqIdx[IDX_W-1:0]] & expand_rmask(imem_rmask);
      end
    end
  end

  // Registered array read; this is the output stage when LATENCY is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      readStage_q <= '0;
    end else begin
      readStage_q <= readStage_d;
    end
  end

  // Program port stays live under reset so the array can be preloaded;
  // a same-edge read sees the old word because the read samples before this.
  always_ff @(posedge clk) begin
    if (prog_we && progOk) begin
      mem[progIdx[IDX_W-1:0]] <= prog_wdata;
    end
  end

  imem_delay_line #(
    .STAGES (LATENCY - 1)
  ) u_delay (
    .clk   (clk),
    .rst   (rst),
    .rsp_i (readStage_q),
    .rsp_o (outRsp)
  );

  assign imem_resp  = outRsp.valid;
  assign imem_rdata = outRsp.rdata;
  assign imem_err   = outRsp.err;

endmodule
